alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
//  Registered, XLEN-parametrised RV integer ALU for the execute stage, with valid/ready on both sides.
//  Base RV32I/RV64I reg-reg ops complete in 1 cycle. Optional RV-M multiply/divide runs on an
//  iterative unit (1 bit per cycle), back-pressuring upstream while busy.
//  Sits between decode/issue and writeback; 1-entry output register.
// PARAMETERS
//  XLEN     32   datapath width; legal values 32 or 64
//  SHAMT_W  localparam = $clog2(XLEN); shift amount is i_datab[SHAMT_W-1:0]
// PORTS
//  i_clk      in   1     clock, rising edge
//  i_rst      in   1     reset, asynchronous, active-high
//  i_valid    in   1     operation request valid
//  o_ready    out  1     block can accept a request this cycle
//  i_dataa    in   XLEN  operand A (rs1)
//  i_datab    in   XLEN  operand B (rs2)
//  i_funct3   in   3     operation select
//  i_sub_sra  in   1     funct7[5]: SUB / SRA select (base ops only)
//  i_muldiv   in   1     funct7[0]: RV-M op select (ignored unless ALU_MULDIV_EN)
//  o_valid    out  1     result valid
//  i_ready    in   1     downstream accepts result
//  o_datac    out  XLEN  result
//  o_busy     out  1     iterative unit active
// BEHAVIOUR
//  Reset values: o_valid=0, o_datac=0, o_busy=0, FSM=S_IDLE, counter=0. o_ready=1 after reset.
//  Accept: i_valid && o_ready. Release: o_valid && i_ready.
//  o_ready = (state==S_IDLE) && (!o_valid || i_ready). Accept and release in the same cycle is legal,
//  giving full throughput for base ops.
//  Held output: o_datac is stable while o_valid && !i_ready. Inputs are sampled only on accept.
//  Base ops, latency 1 (o_valid the cycle after accept):
//   000 ADD, or SUB if i_sub_sra. 010 SLT, signed compare. 011 SLTU, unsigned compare.
//   100 XOR. 110 OR. 111 AND. 001 SLL. 101 SRL, or SRA if i_sub_sra (sign-filling).
//   Adds and subtracts wrap modulo 2^XLEN; no flags. SLT/SLTU return 0 or 1, zero-extended.
//  FSM states: S_IDLE -> S_MUL | S_DIV on accept of an RV-M op.
//   S_MUL|S_DIV -> S_IDLE when the iteration counter reaches XLEN-1, loading o_datac and setting
//   o_valid that cycle. Latency is XLEN+1 cycles from accept to o_valid.
//  MUL: unsigned shift-add on operand magnitudes, with sign fix-up at the end.
//   000 MUL (low half). 001 MULH (s x s). 010 MULHSU (s x u). 011 MULHU (u x u).
//  DIV: restoring divide on magnitudes; quotient sign = sa^sb, remainder sign = sign of dividend.
//   100 DIV. 101 DIVU. 110 REM. 111 REMU.
//  Special cases, latency 1, no S_DIV entry:
//   divide by zero: quotient = all-ones, remainder = dividend.
//   signed overflow (dataa = MIN_INT, datab = -1): quotient = MIN_INT, remainder = 0.
//  i_rst asserted mid-iteration aborts the op immediately: FSM to S_IDLE, o_valid=0, o_datac=0.
//   The partial result is discarded.
//  o_busy = (state != S_IDLE).
// CONFIGURATION
//  ALU_MULDIV_EN defined: RV-M ops available as above.
//  ALU_MULDIV_EN undefined: i_muldiv is ignored (treated as 0); FSM stays in S_IDLE.
//   o_busy is tied 0 and o_ready = !o_valid || i_ready. No iterative logic is synthesised.
// STRUCTURE
//  Shared defines file (defines.v) holds the FUNCT3_* base-op constants plus new FUNCT3_MUL,
//  FUNCT3_MULH, FUNCT3_MULHSU, FUNCT3_MULHU, FUNCT3_DIV, FUNCT3_DIVU, FUNCT3_REM, FUNCT3_REMU.
//  The same file holds the FSM encodings S_IDLE/S_MUL/S_DIV.
//  Sub-module alu_muldiv_iter (XLEN param) contains the counter, the shift-add/restoring datapath
//  and the sign fix-up. It uses a start/done handshake and is instantiated only under ALU_MULDIV_EN.
//  Base ops and the output register are in alu_pipe.
// TESTING
//  1 Reset then ADD 0xFFFFFFFF + 1, i_ready=1 -> o_valid one cycle later, o_datac=0x00000000.
//  2 SLT 0xFFFFFFFF vs 1 -> 1; SLTU same operands -> 0.
//    SRA 0x80000000 >> 4 -> 0xF8000000; SRL -> 0x08000000.
//  3 Hold i_ready=0 across 3 cycles after a result -> o_valid=1, o_datac stable, o_ready=0.
//    Raise i_ready with a new i_valid in that cycle -> back-to-back accept.
//  4 (MULDIV) MULH 0xFFFFFFFE x 3 -> 0xFFFFFFFF after 33 cycles; o_busy=1 and o_ready=0 throughout.
//  5 (MULDIV) DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 in 1 cycle.
//    DIVU 7 / 0 -> 0xFFFFFFFF; REM -7 / 2 -> 0xFFFFFFFF.
//  6 (MULDIV) Assert i_rst at iteration 10 of a DIVU -> same cycle o_valid=0, o_busy=0.
//    After release, ADD 2+3 -> 5 at normal latency.

Source files
------------

// File: rtl/alu_pipe_pkg.sv
// Shared constants for alu_pipe: funct3 op encodings and the RV-M FSM state encoding.
package alu_pipe_pkg;

  // Base integer ops
  localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
  localparam logic [2:0] FUNCT3_SLL     = 3'b001;
  localparam logic [2:0] FUNCT3_SLT     = 3'b010;
  localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
  localparam logic [2:0] FUNCT3_XOR     = 3'b100;
  localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
  localparam logic [2:0] FUNCT3_OR      = 3'b110;
  localparam logic [2:0] FUNCT3_AND     = 3'b111;

  // RV-M ops (funct7[0] set)
  localparam logic [2:0] FUNCT3_MUL     = 3'b000;
  localparam logic [2:0] FUNCT3_MULH    = 3'b001;
  localparam logic [2:0] FUNCT3_MULHSU  = 3'b010;
  localparam logic [2:0] FUNCT3_MULHU   = 3'b011;
  localparam logic [2:0] FUNCT3_DIV     = 3'b100;
  localparam logic [2:0] FUNCT3_DIVU    = 3'b101;
  localparam logic [2:0] FUNCT3_REM     = 3'b110;
  localparam logic [2:0] FUNCT3_REMU    = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

endpackage

// File: rtl/alu_muldiv_iter.sv
// Iterative RV-M unit: 1 bit per cycle shift-add multiply / restoring divide on operand
// magnitudes, sign fix-up applied on the final step. o_done is high in the last iteration
// cycle and o_result is valid in that same cycle.
module alu_muldiv_iter
  import alu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_start,
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_dataa,
  input  logic [XLEN-1:0] i_datab,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CNT_W = $clog2(XLEN);

  // acc holds {high, low}: product accumulator / multiplier for MUL, {remainder, quotient} for DIV
  logic                run_q, run_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_q, neg_d;
  logic                negr_q, negr_d;
  logic [2*XLEN-1:0]   acc_q, acc_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;

  logic                sa, sb, a_neg, b_neg;
  logic [XLEN-1:0]     mag_a, mag_b;
  logic [XLEN:0]       mul_sum, div_shift;
  logic                div_ge;
  logic [XLEN-1:0]     div_rem;
  logic [2*XLEN-1:0]   acc_n, prod_fix;
  logic [XLEN-1:0]     quo, rem;

  // Operand signedness and magnitudes at start
  always_comb begin
    if (i_funct3[2]) begin
      sa = !i_funct3[0];
      sb = !i_funct3[0];
    end else begin
      sa = (i_funct3 == FUNCT3_MULH) || (i_funct3 == FUNCT3_MULHSU);
      sb = (i_funct3 == FUNCT3_MULH);
    end
    a_neg = sa & i_dataa[XLEN-1];
    b_neg = sb & i_datab[XLEN-1];
    mag_a = a_neg ? -i_dataa : i_dataa;
    mag_b = b_neg ? -i_datab : i_datab;
  end

  // One iteration step of either algorithm, plus the signed final result
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
    div_ge    = div_shift >= {1'b0, opnd_q};
    div_rem   = div_ge ? XLEN'(div_shift - {1'b0, opnd_q}) : div_shift[XLEN-1:0];
    if (f3_q[2]) acc_n = {div_rem, acc_q[XLEN-2:0], div_ge};
    else         acc_n = {mul_sum, acc_q[XLEN-1:1]};
    prod_fix = neg_q ? -acc_n : acc_n;
    quo      = neg_q ? -acc_n[XLEN-1:0] : acc_n[XLEN-1:0];
    rem      = negr_q ? -acc_n[2*XLEN-1:XLEN] : acc_n[2*XLEN-1:XLEN];
    o_done   = run_q && (cnt_q == CNT_W'(XLEN-1));
    if (f3_q[2])                  o_result = f3_q[1] ? rem : quo;
    else if (f3_q == FUNCT3_MUL)  o_result = prod_fix[XLEN-1:0];
    else                          o_result = prod_fix[2*XLEN-1:XLEN];
  end

  // Load on start, step while running, stop after the last iteration
  always_comb begin
    run_d  = run_q;
    cnt_d  = cnt_q;
    f3_d   = f3_q;
    neg_d  = neg_q;
    negr_d = negr_q;
    acc_d  = acc_q;
    opnd_d = opnd_q;
    if (i_start) begin
      run_d  = 1'b1;
      cnt_d  = '0;
      f3_d   = i_funct3;
      neg_d  = a_neg ^ b_neg;
      negr_d = a_neg;
      acc_d  = {{XLEN{1'b0}}, mag_a};
      opnd_d = mag_b;
    end else if (run_q) begin
      acc_d = acc_n;
      cnt_d = cnt_q + 1'b1;
      if (o_done) begin
        run_d = 1'b0;
        cnt_d = '0;
      end
    end
  end

  // Iteration state registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      run_q  <= 1'b0;
      cnt_q  <= '0;
      f3_q   <= '0;
      neg_q  <= 1'b0;
      negr_q <= 1'b0;
      acc_q  <= '0;
      opnd_q <= '0;
    end else begin
      run_q  <= run_d;
      cnt_q  <= cnt_d;
      f3_q   <= f3_d;
      neg_q  <= neg_d;
      negr_q <= negr_d;
      acc_q  <= acc_d;
      opnd_q <= opnd_d;
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: registered RV integer ALU with valid/ready on both sides and a 1-entry output register.
// Optional RV-M support is enabled by defining ALU_MULDIV_EN.
//
//  state  | meaning
//  S_IDLE | accepting requests; base ops complete here
//  S_MUL  | iterative multiply in progress, upstream stalled
//  S_DIV  | iterative divide in progress, upstream stalled
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_valid,
  output logic            o_ready,
  input  logic [XLEN-1:0] i_dataa,
  input  logic [XLEN-1:0] i_datab,
  input  logic [2:0]      i_funct3,
  input  logic            i_sub_sra,
  input  logic            i_muldiv,
  output logic            o_valid,
  input  logic            i_ready,
  output logic [XLEN-1:0] o_datac,
  output logic            o_busy
);

  localparam int SHAMT_W = $clog2(XLEN);

  logic                valid_q, valid_d;
  logic [XLEN-1:0]     datac_q, datac_d;
  logic                accept, rel;
  logic [SHAMT_W-1:0]  shamt;
  logic [XLEN-1:0]     base_res, acc_res, done_res;
  logic                start_w, done_w;

  assign accept = i_valid && o_ready;
  assign rel    = valid_q && i_ready;
  assign shamt  = i_datab[SHAMT_W-1:0];

  // Single-cycle base op result
  always_comb begin
    base_res = '0;
    case (i_funct3)
      FUNCT3_ADD_SUB: base_res = i_sub_sra ? i_dataa - i_datab : i_dataa + i_datab;
      FUNCT3_SLL:     base_res = i_dataa << shamt;
      FUNCT3_SLT:     base_res = {{(XLEN-1){1'b0}}, ($signed(i_dataa) < $signed(i_datab))};
      FUNCT3_SLTU:    base_res = {{(XLEN-1){1'b0}}, (i_dataa < i_datab)};
      FUNCT3_XOR:     base_res = i_dataa ^ i_datab;
      FUNCT3_SRL_SRA: base_res = i_sub_sra ? $unsigned($signed(i_dataa) >>> shamt)
                                           : i_dataa >> shamt;
      FUNCT3_OR:      base_res = i_dataa | i_datab;
      FUNCT3_AND:     base_res = i_dataa & i_datab;
      default:        base_res = '0;
    endcase
  end

`ifdef ALU_MULDIV_EN
  localparam logic [XLEN-1:0] MIN_INT = {1'b1, {(XLEN-1){1'b0}}};

  state_e          state_q, state_d;
  logic            div_zero, div_ovf, special;
  logic [XLEN-1:0] spec_res;

  // Divide by zero and signed overflow finish in one cycle without entering S_DIV
  always_comb begin
    div_zero = (i_datab == '0);
    div_ovf  = !i_funct3[0] && (i_dataa == MIN_INT) && (i_datab == '1);
    special  = i_muldiv && i_funct3[2] && (div_zero || div_ovf);
    if (div_zero) spec_res = i_funct3[1] ? i_dataa : '1;
    else          spec_res = i_funct3[1] ? '0 : MIN_INT;
    acc_res = special ? spec_res : base_res;
    start_w = accept && i_muldiv && !special;
  end

  alu_muldiv_iter #(.XLEN(XLEN)) u_iter (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_start  (start_w),
    .i_funct3 (i_funct3),
    .i_dataa  (i_dataa),
    .i_datab  (i_datab),
    .o_done   (done_w),
    .o_result (done_res)
  );

  // FSM state register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:       if (start_w) state_d = i_funct3[2] ? S_DIV : S_MUL;
      S_MUL, S_DIV: if (done_w) state_d = S_IDLE;
      default:      state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    o_busy  = (state_q != S_IDLE);
    o_ready = (state_q == S_IDLE) && (!valid_q || i_ready);
  end
`else
  logic unused_muldiv;

  assign unused_muldiv = i_muldiv;
  assign acc_res       = base_res;
  assign start_w       = 1'b0;
  assign done_w        = 1'b0;
  assign done_res      = '0;
  assign o_busy        = 1'b0;
  assign o_ready       = !valid_q || i_ready;
`endif

  // Output register: load on accept or iterative completion, clear on release
  always_comb begin
    valid_d = valid_q;
    datac_d = datac_q;
    if (rel) valid_d = 1'b0;
    if (accept && !start_w) begin
      valid_d = 1'b1;
      datac_d = acc_res;
    end
    if (done_w) begin
      valid_d = 1'b1;
      datac_d = done_res;
    end
  end

  // Output register flops
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      datac_q <= '0;
    end else begin
      valid_q <= valid_d;
      datac_q <= datac_d;
    end
  end

  assign o_valid = valid_q;
  assign o_datac = datac_q;

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe (XLEN=32). RV-M steps are compiled when ALU_MULDIV_EN is defined.
module tb_alu_pipe;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_dataa;
  logic [31:0] i_datab;
  logic [2:0]  i_funct3;
  logic        i_sub_sra;
  logic        i_muldiv;
  logic        o_valid;
  logic        i_ready;
  logic [31:0] o_datac;
  logic        o_busy;

  int n_asrt = 0;
  int n_fail = 0;

  alu_pipe #(.XLEN(32)) dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_dataa   (i_dataa),
    .i_datab   (i_datab),
    .i_funct3  (i_funct3),
    .i_sub_sra (i_sub_sra),
    .i_muldiv  (i_muldiv),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_datac   (o_datac),
    .o_busy    (o_busy)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asrt++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one request and return 1ns after the edge that accepts it
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [2:0] f3,
                       input logic sub, input logic md);
    i_valid   = 1'b1;
    i_dataa   = a;
    i_datab   = b;
    i_funct3  = f3;
    i_sub_sra = sub;
    i_muldiv  = md;
    @(posedge i_clk);
    #1;
    i_valid  = 1'b0;
    i_muldiv = 1'b0;
  endtask

  task automatic base_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic sub, input logic [31:0] exp);
    issue(a, b, f3, sub, 1'b0);
    chk({tag, "_valid"}, {31'd0, o_valid}, 32'd1);
    chk(tag, o_datac, exp);
  endtask

`ifdef ALU_MULDIV_EN
  // Iterative op: expects busy/!ready until the result, and XLEN+1 cycles of latency
  task automatic md_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] f3, input logic [31:0] exp);
    int  n;
    logic stall_ok;
    issue(a, b, f3, 1'b0, 1'b1);
    n = 1;
    stall_ok = 1'b1;
    while (o_valid !== 1'b1 && n < 200) begin
      stall_ok &= (o_busy === 1'b1) && (o_ready === 1'b0);
      @(posedge i_clk);
      #1;
      n++;
    end
    chk({tag, "_stall"}, {31'd0, stall_ok}, 32'd1);
    chk({tag, "_latency"}, n, 32'd33);
    chk(tag, o_datac, exp);
    chk({tag, "_busy_end"}, {31'd0, o_busy}, 32'd0);
  endtask
`endif

  initial begin
    i_rst = 1'b1; i_valid = 1'b0; i_dataa = '0; i_datab = '0;
    i_funct3 = '0; i_sub_sra = 1'b0; i_muldiv = 1'b0; i_ready = 1'b1;
    repeat (3) @(posedge i_clk);
    #1;
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_datac", o_datac, 32'd0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    i_rst = 1'b0;
    #1;
    chk("rst_ready", {31'd0, o_ready}, 32'd1);

    base_op("add_wrap", 32'hFFFF_FFFF, 32'h0000_0001, 3'b000, 1'b0, 32'h0000_0000);
    base_op("sub",      32'h0000_0005, 32'h0000_0007, 3'b000, 1'b1, 32'hFFFF_FFFE);
    base_op("slt",      32'hFFFF_FFFF, 32'h0000_0001, 3'b010, 1'b0, 32'h0000_0001);
    base_op("sltu",     32'hFFFF_FFFF, 32'h0000_0001, 3'b011, 1'b0, 32'h0000_0000);
    base_op("sra",      32'h8000_0000, 32'h0000_0004, 3'b101, 1'b1, 32'hF800_0000);
    base_op("srl",      32'h8000_0000, 32'h0000_0004, 3'b101, 1'b0, 32'h0800_0000);
    base_op("xor",      32'hF0F0_1234, 32'h0FF0_00FF, 3'b100, 1'b0, 32'hFF00_12CB);
    base_op("or",       32'hF0F0_1234, 32'h0FF0_00FF, 3'b110, 1'b0, 32'hFFF0_12FF);
    base_op("and",      32'hF0F0_1234, 32'h0FF0_00FF, 3'b111, 1'b0, 32'h00F0_0034);
    base_op("sll_31",   32'h0000_0001, 32'h0000_003F, 3'b001, 1'b0, 32'h8000_0000);

    // Back-pressure: hold the result while a new request waits
    i_ready = 1'b0;
    @(posedge i_clk);
    #1;
    chk("drain_valid", {31'd0, o_valid}, 32'd1);
    chk("drain_hold", o_datac, 32'h8000_0000);
    i_ready = 1'b1;
    @(posedge i_clk);
    #1;
    chk("drained", {31'd0, o_valid}, 32'd0);
    i_ready = 1'b0;
    base_op("add_hold", 32'd2, 32'd3, 3'b000, 1'b0, 32'd5);
    i_valid = 1'b1; i_dataa = 32'd10; i_datab = 32'd20; i_funct3 = 3'b000; i_sub_sra = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk("hold_valid", {31'd0, o_valid}, 32'd1);
      chk("hold_datac", o_datac, 32'd5);
      chk("hold_ready", {31'd0, o_ready}, 32'd0);
      @(posedge i_clk);
      #1;
    end
    i_ready = 1'b1;
    #1;
    chk("release_ready", {31'd0, o_ready}, 32'd1);
    @(posedge i_clk);
    #1;
    i_valid = 1'b0;
    chk("b2b_valid", {31'd0, o_valid}, 32'd1);
    chk("b2b_datac", o_datac, 32'd30);
    @(posedge i_clk);
    #1;
    chk("b2b_drop", {31'd0, o_valid}, 32'd0);

`ifdef ALU_MULDIV_EN
    md_op("mulh",  32'hFFFF_FFFE, 32'h0000_0003, 3'b001, 32'hFFFF_FFFF);
    md_op("mulhu", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011, 32'hFFFF_FFFE);
    md_op("mul",   32'h0000_0007, 32'h0000_0006, 3'b000, 32'h0000_002A);
    md_op("div",   32'hFFFF_FFF9, 32'h0000_0002, 3'b100, 32'hFFFF_FFFD);
    md_op("rem",   32'hFFFF_FFF9, 32'h0000_0002, 3'b110, 32'hFFFF_FFFF);
    md_op("divu",  32'h0000_0064, 32'h0000_0007, 3'b101, 32'h0000_000E);

    issue(32'h8000_0000, 32'hFFFF_FFFF, 3'b100, 1'b0, 1'b1);
    chk("div_ovf_valid", {31'd0, o_valid}, 32'd1);
    chk("div_ovf", o_datac, 32'h8000_0000);
    chk("div_ovf_busy", {31'd0, o_busy}, 32'd0);
    issue(32'h0000_0007, 32'h0000_0000, 3'b101, 1'b0, 1'b1);
    chk("divu_zero_valid", {31'd0, o_valid}, 32'd1);
    chk("divu_zero", o_datac, 32'hFFFF_FFFF);
    issue(32'h0000_0007, 32'h0000_0000, 3'b111, 1'b0, 1'b1);
    chk("remu_zero", o_datac, 32'h0000_0007);
    issue(32'h8000_0000, 32'hFFFF_FFFF, 3'b110, 1'b0, 1'b1);
    chk("rem_ovf", o_datac, 32'h0000_0000);

    // Abort an iterative divide with reset
    issue(32'h1234_5678, 32'h0000_0003, 3'b101, 1'b0, 1'b1);
    repeat (10) @(posedge i_clk);
    #2;
    chk("abort_busy_pre", {31'd0, o_busy}, 32'd1);
    i_rst = 1'b1;
    #1;
    chk("abort_valid", {31'd0, o_valid}, 32'd0);
    chk("abort_busy", {31'd0, o_busy}, 32'd0);
    chk("abort_datac", o_datac, 32'd0);
    @(posedge i_clk);
    #1;
    i_rst = 1'b0;
    #1;
    base_op("add_post_abort", 32'd2, 32'd3, 3'b000, 1'b0, 32'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end

endmodule
